// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch path: FSM encoding and imem widths.
package if_pkg;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_ADDR_W = 11;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Small synchronous prefetch FIFO; registered head/valid, no push-to-head bypass.
// Latency: a pushed word reaches the head the cycle after the push.
module inst_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_pop;

    assign valid  = (count_q != '0);
    assign do_pop = pop && valid;
    assign head   = valid ? mem_q[rd_ptr_q] : '0;
    assign count  = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // The credit logic upstream must make a full-without-pop push impossible.
            assert (!(push && !do_pop && count_q == (PW+1)'(DEPTH)));
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Sequential imem reader feeding the decoder through a credit-managed prefetch FIFO.
// Latency start->first inst_valid is 3 cycles; reads throttle on FIFO credits when inst_ready is low.
module instruction_fetch import if_pkg::*; #(
    parameter int DATA_WIDTH = IMEM_DATA_W,
    parameter int ADDR_WIDTH = IMEM_ADDR_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_W-1:0]      num_inst,
    output logic                  busy,
    output logic                  done,
    output logic                  imem_read_req,
    output logic [ADDR_WIDTH-1:0] imem_read_addr,
    input  logic [DATA_WIDTH-1:0] imem_read_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic                  inst_last
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    if_state_e             state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  zero_done_q, zero_done_d;
    logic                  req_q, req_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [CNT_W-1:0]      reads_left_q, reads_left_d;
    logic [CNT_W-1:0]      num_inst_q, num_inst_d;
    logic [CNT_W-1:0]      delivered_q, delivered_d;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           credits_used;
    logic                  pop, last_hs;

    assign pop       = inst_valid && inst_ready;
    assign inst_last = inst_valid && (delivered_q == num_inst_q - ONE);
    assign last_hs   = pop && inst_last;

    // A word occupies a credit from its request until it leaves the FIFO:
    // request cycle (req_q), return cycle (inflight_q), then FIFO storage.
    assign credits_used = {1'b0, fifo_count} + (CW+1)'(req_q) + (CW+1)'(inflight_q);

    assign busy           = busy_q;
    assign done           = zero_done_q || (state_q == IF_DRAIN && last_hs);
    assign imem_read_req  = req_q;
    assign imem_read_addr = addr_q;

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        zero_done_d  = 1'b0;
        req_d        = 1'b0;
        inflight_d   = req_q;
        addr_d       = addr_q;
        next_addr_d  = next_addr_q;
        reads_left_d = reads_left_q;
        num_inst_d   = num_inst_q;
        delivered_d  = delivered_q + (pop ? ONE : '0);
        case (state_q)
            IF_IDLE: begin
                if (start && num_inst == '0) begin
                    zero_done_d = 1'b1;
                end else if (start) begin
                    num_inst_d   = num_inst;
                    delivered_d  = '0;
                    req_d        = 1'b1;
                    addr_d       = base_addr;
                    next_addr_d  = base_addr + ADDR_WIDTH'(1);
                    reads_left_d = num_inst - ONE;
                    busy_d       = 1'b1;
                    state_d      = (num_inst == ONE) ? IF_DRAIN : IF_FETCH;
                end
            end
            IF_FETCH: begin
                if (reads_left_q != '0 && credits_used < (CW+1)'(FIFO_DEPTH)) begin
                    req_d        = 1'b1;
                    addr_d       = next_addr_q;
                    next_addr_d  = next_addr_q + ADDR_WIDTH'(1);
                    reads_left_d = reads_left_q - ONE;
                    if (reads_left_q == ONE) begin
                        state_d = IF_DRAIN;
                    end
                end
            end
            IF_DRAIN: begin
                if (last_hs) begin
                    state_d = IF_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IF_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IF_IDLE;
            busy_q       <= 1'b0;
            zero_done_q  <= 1'b0;
            req_q        <= 1'b0;
            inflight_q   <= 1'b0;
            addr_q       <= '0;
            next_addr_q  <= '0;
            reads_left_q <= '0;
            num_inst_q   <= '0;
            delivered_q  <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            zero_done_q  <= zero_done_d;
            req_q        <= req_d;
            inflight_q   <= inflight_d;
            addr_q       <= addr_d;
            next_addr_q  <= next_addr_d;
            reads_left_q <= reads_left_d;
            num_inst_q   <= num_inst_d;
            delivered_q  <= delivered_d;
        end
    end

    inst_fetch_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (imem_read_data),
        .pop       (pop),
        .head      (inst_data),
        .valid     (inst_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a run model queues expected reads and
// instructions at start; a negedge monitor pops and compares whatever the DUT presents.
module tb_instruction_fetch;

    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int DEPTH = 4;
    localparam int CW    = AW + 1;
    localparam int AMOD  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, start, inst_ready;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] num_inst;
    logic          busy, done, imem_read_req, inst_valid, inst_last;
    logic [AW-1:0] imem_read_addr;
    logic [DW-1:0] imem_read_data, inst_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int exp_addr [$];
    int exp_data [$];
    bit exp_last [$];
    bit model_busy    = 1'b0;
    int zero_done_cyc = -1;
    int t_start       = 0;
    int first_req_cyc   = -1;
    int first_valid_cyc = -1;
    int done_cyc   = -1;
    int done_count = 0;
    int req_count  = 0;
    int outstanding = 0;
    int peak_out    = 0;
    bit rand_ready  = 1'b0;
    bit ready_hold  = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // imem port B: one-cycle read latency, data equals the word address.
    always @(posedge clk)
        imem_read_data <= imem_read_req ? DW'(imem_read_addr) : 32'hDEAD_BEEF;

    instruction_fetch #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .num_inst       (num_inst),
        .busy           (busy),
        .done           (done),
        .imem_read_req  (imem_read_req),
        .imem_read_addr (imem_read_addr),
        .imem_read_data (imem_read_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_last      (inst_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        inst_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            inst_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
        end
    end

    always @(negedge clk) begin : monitor
        bit hs;
        bit exp_done;
        if (reset) begin
            hs       = inst_valid && inst_ready;
            exp_done = (cyc == zero_done_cyc);
            if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (imem_read_req) begin
                req_count++;
                outstanding++;
                if (outstanding > peak_out) peak_out = outstanding;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                check("outstanding_le_depth", outstanding > DEPTH, 0);
                if (exp_addr.size() == 0) check("unexpected_read", imem_read_req, 0);
                else check("read_addr", imem_read_addr, exp_addr.pop_front());
            end
            if (hs) begin
                outstanding--;
                if (exp_data.size() == 0) begin
                    check("unexpected_inst", inst_valid, 0);
                end else begin
                    exp_done = exp_done || exp_last[0];
                    if (exp_last[0]) model_busy = 1'b0;
                    check("inst_data", inst_data, exp_data.pop_front());
                    check("inst_last", inst_last, exp_last.pop_front());
                end
            end
            if (done || exp_done) check("done", done, exp_done);
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_run(input int base, input int n);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = AW'(base);
        num_inst  = CW'(n);
        if (!model_busy) begin
            t_start         = cyc;
            first_req_cyc   = -1;
            first_valid_cyc = -1;
            if (n == 0) begin
                zero_done_cyc = cyc + 1;
            end else begin
                model_busy = 1'b1;
                for (int i = 0; i < n; i++) begin
                    exp_addr.push_back((base + i) % AMOD);
                    exp_data.push_back((base + i) % AMOD);
                    exp_last.push_back(i == n - 1);
                end
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((model_busy || exp_data.size() != 0 || busy) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_timeout"}, n >= 1000, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_req"}, imem_read_req, 0);
        check({name, "_addr"}, imem_read_addr, 0);
        check({name, "_valid"}, inst_valid, 0);
        check({name, "_last"}, inst_last, 0);
        check({name, "_data"}, inst_data, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, rc, n;
        reset = 1'b0; start = 1'b0; base_addr = '0; num_inst = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;

        // Basic run, ready held high: exact latencies.
        start_run(32'h010, 5);
        check("t1_busy_at_T1", busy, 1);
        wait_idle("t1");
        check("t1_first_req", first_req_cyc - t_start, 1);
        check("t1_first_valid", first_valid_cyc - t_start, 3);
        check("t1_done_cycle", done_cyc - t_start, 7);

        // Zero count: done at T+1, never busy, no reads.
        dc = done_count; rc = req_count;
        start_run(32'h055, 0);
        check("zero_done_T1", done, 1);
        check("zero_busy", busy, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("zero_busy_stays_low", busy, 0);
        end
        check("zero_done_once", done_count - dc, 1);
        check("zero_no_reads", req_count - rc, 0);

        // Address wrap.
        start_run(32'h7FE, 4);
        wait_idle("wrap");

        // Backpressure: ready low for 8 cycles after first valid.
        ready_hold = 1'b0; peak_out = 0; rc = req_count;
        start_run(32'h050, 10);
        n = 0;
        while (!inst_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_timeout", n >= 50, 0);
        repeat (8) @(posedge clk);
        ready_hold = 1'b1;
        wait_idle("bp");
        check("bp_peak_outstanding", peak_out, DEPTH);
        check("bp_read_count", req_count - rc, 10);

        // Reset mid-run with a read in flight.
        start_run(32'h100, 8);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_addr.delete(); exp_data.delete(); exp_last.delete();
        model_busy = 1'b0; zero_done_cyc = -1; outstanding = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_reset_outputs("midrst");
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_no_stale_valid", inst_valid, 0);
        end
        dc = done_count;
        start_run(32'h020, 2);
        wait_idle("postrst");
        check("postrst_done_once", done_count - dc, 1);

        // Second start while busy is ignored.
        dc = done_count; rc = req_count;
        start_run(32'h300, 6);
        start_run(32'h400, 3);
        wait_idle("dblstart");
        check("dblstart_done_once", done_count - dc, 1);
        check("dblstart_reads", req_count - rc, 6);

        // Random runs with random ready and occasional ignored restarts.
        rand_ready = 1'b1;
        for (int r = 0; r < 25; r++) begin
            start_run($urandom_range(0, AMOD - 1), $urandom_range(0, 12));
            if ($urandom_range(0, 2) == 0)
                start_run($urandom_range(0, AMOD - 1), $urandom_range(1, 12));
            wait_idle("rand");
        end
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("final_words_pending", exp_data.size(), 0);
        check("final_reads_pending", exp_addr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
